// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the IF_ID/ID_EX/EX_MEM/MEM_WB registers and the PC: stall, bubble, freeze and flush
// decisions, EPC/cause capture and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p1_memRead,
    input  logic [2:0]       p1_rd_load,
    input  logic [11:0]      id_src,
    input  logic [3:0]       id_src_valid,
    input  logic             mem_busy,
    input  logic             p1_cause,
    input  logic             p1_invalid,
    input  logic [31:0]      p1_pc,
    output logic             pc_write,
    output logic             pc_sel_vec,
    output logic             IF_Write,
    output logic             ID_Write,
    output logic             EX_MEMregWrite,
    output logic             MEM_WBregWrite,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [31:0]      epc,
    output logic [1:0]       cause_reg,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    localparam logic [2:0] BUBBLE_INIT = 3'(LOAD_STALL - 1);

    logic [1:0] state, nextState;
    logic [2:0] bubbleCnt, nextBubble;
    logic       srcHit, loadUse, exc;
    logic       freeze, bubble, excFlush, vecLoad, capture;

    always_comb begin
        srcHit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (id_src_valid[i] && (id_src[3*i +: 3] == p1_rd_load)) srcHit = 1'b1;
        end
    end

    assign loadUse = p1_memRead & srcHit;
    assign exc     = p1_cause | p1_invalid;

    always_comb begin
        // NOTE: every term written here gets a default first, so no path can infer a latch.
        freeze     = 1'b0;
        bubble     = 1'b0;
        excFlush   = 1'b0;
        vecLoad    = 1'b0;
        capture    = 1'b0;
        nextState  = state;
        nextBubble = bubbleCnt;
        if (state == STALL) begin
            // A memory wait freezes the bubble sequence without consuming a bubble.
            if (mem_busy) begin
                freeze = 1'b1;
            end else begin
                bubble = 1'b1;
                if (bubbleCnt <= 3'd1) begin
                    nextState  = RUN;
                    nextBubble = '0;
                end else begin
                    nextBubble = bubbleCnt - 3'd1;
                end
            end
        end else if (state == FLUSH) begin
            vecLoad   = 1'b1;
            nextState = RUN;
        end else if (state == WAIT && mem_busy) begin
            freeze = 1'b1;
        end else if (exc) begin
            excFlush  = 1'b1;
            capture   = 1'b1;
            nextState = FLUSH;
        end else if (mem_busy) begin
            freeze    = 1'b1;
            nextState = WAIT;
        end else if (loadUse) begin
            bubble = 1'b1;
            if (LOAD_STALL > 1) begin
                nextState  = STALL;
                nextBubble = BUBBLE_INIT;
            end else begin
                nextState = RUN;
            end
        end else begin
            nextState = RUN;
        end
    end

    // While reset is held every pipeline register is flushed and nothing advances.
    assign pc_write       = reset & ~(freeze | bubble | excFlush);
    assign pc_sel_vec     = reset & vecLoad;
    assign IF_Write       = reset & ~(freeze | bubble);
    assign ID_Write       = reset & ~freeze;
    assign EX_MEMregWrite = reset & ~freeze;
    assign MEM_WBregWrite = reset & ~freeze;
    assign flush_if_id    = ~reset | excFlush;
    assign flush_id_ex    = ~reset | excFlush | bubble;
    assign flush_ex_mem   = ~reset | excFlush;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state     <= RUN;
            bubbleCnt <= '0;
            epc       <= '0;
            cause_reg <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= nextState;
            bubbleCnt <= nextBubble;
            if (capture) begin
                epc       <= p1_pc;
                cause_reg <= {p1_invalid, p1_cause};
            end
            if (!IF_Write && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three instances (default, LOAD_STALL=3, CNT_W=4) share one
// stimulus stream; each scenario task checks the instance it exercises.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        rst;
        logic        memRead;
        logic [2:0]  rd;
        logic [11:0] src;
        logic [3:0]  srcV;
        logic        busy;
        logic        cs;
        logic        inv;
        logic [31:0] pc;
    } stim_t;

    typedef struct packed {
        logic        pcW;
        logic        sel;
        logic        ifW;
        logic        idW;
        logic        exW;
        logic        wbW;
        logic        fIf;
        logic        fId;
        logic        fEx;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic [15:0] cnt;
    } obs_t;

    typedef enum {K_RUN, K_BUB, K_FRZ, K_EXC, K_VEC, K_RST} kind_e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, p1_memRead, mem_busy, p1_cause, p1_invalid;
    logic [2:0]  p1_rd_load;
    logic [11:0] id_src;
    logic [3:0]  id_src_valid;
    logic [31:0] p1_pc;

    logic        pcWrite [3];
    logic        pcSelVec [3];
    logic        ifWrite [3];
    logic        idWrite [3];
    logic        exWrite [3];
    logic        wbWrite [3];
    logic        flushIf [3];
    logic        flushId [3];
    logic        flushEx [3];
    logic [31:0] epcOut [3];
    logic [1:0]  causeOut [3];
    logic [15:0] cntA, cntB;
    logic [3:0]  cntC;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t sb[$];

    pipe_hazard_ctrl dutA (
        .clk(clk), .reset(reset), .p1_memRead(p1_memRead), .p1_rd_load(p1_rd_load), .id_src(id_src),
        .id_src_valid(id_src_valid), .mem_busy(mem_busy), .p1_cause(p1_cause), .p1_invalid(p1_invalid),
        .p1_pc(p1_pc), .pc_write(pcWrite[0]), .pc_sel_vec(pcSelVec[0]), .IF_Write(ifWrite[0]),
        .ID_Write(idWrite[0]), .EX_MEMregWrite(exWrite[0]), .MEM_WBregWrite(wbWrite[0]),
        .flush_if_id(flushIf[0]), .flush_id_ex(flushId[0]), .flush_ex_mem(flushEx[0]),
        .epc(epcOut[0]), .cause_reg(causeOut[0]), .stall_cnt(cntA)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(3)) dutB (
        .clk(clk), .reset(reset), .p1_memRead(p1_memRead), .p1_rd_load(p1_rd_load), .id_src(id_src),
        .id_src_valid(id_src_valid), .mem_busy(mem_busy), .p1_cause(p1_cause), .p1_invalid(p1_invalid),
        .p1_pc(p1_pc), .pc_write(pcWrite[1]), .pc_sel_vec(pcSelVec[1]), .IF_Write(ifWrite[1]),
        .ID_Write(idWrite[1]), .EX_MEMregWrite(exWrite[1]), .MEM_WBregWrite(wbWrite[1]),
        .flush_if_id(flushIf[1]), .flush_id_ex(flushId[1]), .flush_ex_mem(flushEx[1]),
        .epc(epcOut[1]), .cause_reg(causeOut[1]), .stall_cnt(cntB)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dutC (
        .clk(clk), .reset(reset), .p1_memRead(p1_memRead), .p1_rd_load(p1_rd_load), .id_src(id_src),
        .id_src_valid(id_src_valid), .mem_busy(mem_busy), .p1_cause(p1_cause), .p1_invalid(p1_invalid),
        .p1_pc(p1_pc), .pc_write(pcWrite[2]), .pc_sel_vec(pcSelVec[2]), .IF_Write(ifWrite[2]),
        .ID_Write(idWrite[2]), .EX_MEMregWrite(exWrite[2]), .MEM_WBregWrite(wbWrite[2]),
        .flush_if_id(flushIf[2]), .flush_id_ex(flushId[2]), .flush_ex_mem(flushEx[2]),
        .epc(epcOut[2]), .cause_reg(causeOut[2]), .stall_cnt(cntC)
    );

    function automatic stim_t mkStim(bit rst, bit ld, logic [11:0] src, logic [3:0] v, bit busy,
                                     bit cs, bit inv, logic [31:0] pc);
        stim_t s;
        s.rst = rst; s.memRead = ld; s.rd = 3'd3; s.src = src; s.srcV = v;
        s.busy = busy; s.cs = cs; s.inv = inv; s.pc = pc;
        return s;
    endfunction

    function automatic stim_t idle();
        return mkStim(1, 0, 12'o0000, 4'h0, 0, 0, 0, 32'h0);
    endfunction

    function automatic stim_t ldS1();
        return mkStim(1, 1, 12'o7135, 4'b0010, 0, 0, 0, 32'h0);
    endfunction

    function automatic obs_t mkExp(kind_e k, logic [31:0] e, logic [1:0] c, int n);
        logic [8:0] ctl;
        case (k)
            K_RUN:   ctl = 9'b1_0_1111_000;
            K_BUB:   ctl = 9'b0_0_0111_010;
            K_FRZ:   ctl = 9'b0_0_0000_000;
            K_EXC:   ctl = 9'b0_0_1111_111;
            K_VEC:   ctl = 9'b1_1_1111_000;
            default: ctl = 9'b0_0_0000_111;
        endcase
        return {ctl, e, c, 16'(n)};
    endfunction

    function automatic obs_t sample(int w);
        obs_t o;
        o = {pcWrite[w], pcSelVec[w], ifWrite[w], idWrite[w], exWrite[w], wbWrite[w],
             flushIf[w], flushId[w], flushEx[w], epcOut[w], causeOut[w], 16'h0};
        o.cnt = (w == 0) ? cntA : (w == 1) ? cntB : {12'h0, cntC};
        return o;
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        reset = s.rst; p1_memRead = s.memRead; p1_rd_load = s.rd; id_src = s.src;
        id_src_valid = s.srcV; mem_busy = s.busy; p1_cause = s.cs; p1_invalid = s.inv; p1_pc = s.pc;
    endtask

    task automatic do_reset();
        drive(mkStim(0, 0, 12'o0000, 4'h0, 0, 0, 0, 32'h0));
    endtask

    task automatic test_reset();
        obs_t got, want;
        do_reset();
        drive(mkStim(0, 1, 12'o7135, 4'hF, 1, 1, 1, 32'h44));
        for (int w = 0; w < 3; w++) sb.push_back(mkExp(K_RST, 32'h0, 2'b00, 0));
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            got = sample(w); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[dut%0d]: got %h, want %h", w, got, want);
            end
        end
        drive(idle());
        for (int w = 0; w < 3; w++) sb.push_back(mkExp(K_RUN, 32'h0, 2'b00, 0));
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            got = sample(w); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_release[dut%0d]: got %h, want %h", w, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(ldS1());                                       ex.push_back(mkExp(K_BUB, 0, 0, 0));
        st.push_back(idle());                                       ex.push_back(mkExp(K_RUN, 0, 0, 1));
        st.push_back(mkStim(1, 1, 12'o3145, 4'b1000, 0, 0, 0, 0));  ex.push_back(mkExp(K_BUB, 0, 0, 1));
        st.push_back(idle());                                       ex.push_back(mkExp(K_RUN, 0, 0, 2));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            got = sample(0); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got %h, want %h", i, got, want);
            end
        end
    endtask

    task automatic test_no_hazard();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(mkStim(1, 1, 12'o7135, 4'b1101, 0, 0, 0, 0)); ex.push_back(mkExp(K_RUN, 0, 0, 2));
        st.push_back(mkStim(1, 1, 12'o7145, 4'hF, 0, 0, 0, 0));    ex.push_back(mkExp(K_RUN, 0, 0, 2));
        st.push_back(mkStim(1, 0, 12'o7135, 4'hF, 0, 0, 0, 0));    ex.push_back(mkExp(K_RUN, 0, 0, 2));
        st.push_back(mkStim(1, 1, 12'o7135, 4'h0, 0, 0, 0, 0));    ex.push_back(mkExp(K_RUN, 0, 0, 2));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            got = sample(0); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL no_hazard[%0d]: got %h, want %h", i, got, want);
            end
        end
    endtask

    task automatic test_exception();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(mkStim(1, 0, 0, 0, 0, 0, 1, 32'h40));          ex.push_back(mkExp(K_EXC, 32'h0, 2'b00, 2));
        st.push_back(mkStim(1, 0, 0, 0, 0, 1, 1, 32'h80));          ex.push_back(mkExp(K_VEC, 32'h40, 2'b10, 2));
        st.push_back(idle());                                       ex.push_back(mkExp(K_RUN, 32'h40, 2'b10, 2));
        st.push_back(mkStim(1, 0, 0, 0, 0, 1, 0, 32'h100));         ex.push_back(mkExp(K_EXC, 32'h40, 2'b10, 2));
        st.push_back(idle());                                       ex.push_back(mkExp(K_VEC, 32'h100, 2'b01, 2));
        st.push_back(mkStim(1, 1, 12'o7135, 4'hF, 1, 1, 1, 32'h200)); ex.push_back(mkExp(K_EXC, 32'h100, 2'b01, 2));
        st.push_back(idle());                                       ex.push_back(mkExp(K_VEC, 32'h200, 2'b11, 2));
        st.push_back(idle());                                       ex.push_back(mkExp(K_RUN, 32'h200, 2'b11, 2));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            got = sample(0); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL exception[%0d]: got %h, want %h", i, got, want);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(mkStim(1, 1, 12'o7135, 4'b0010, 1, 0, 0, 0));     ex.push_back(mkExp(K_FRZ, 0, 0, 0));
        st.push_back(mkStim(1, 1, 12'o7135, 4'b0010, 1, 0, 1, 32'h55)); ex.push_back(mkExp(K_FRZ, 0, 0, 1));
        st.push_back(mkStim(1, 1, 12'o7135, 4'b0010, 1, 0, 0, 0));     ex.push_back(mkExp(K_FRZ, 0, 0, 2));
        st.push_back(ldS1());                                           ex.push_back(mkExp(K_BUB, 0, 0, 3));
        st.push_back(idle());                                           ex.push_back(mkExp(K_RUN, 0, 0, 4));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            got = sample(0); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mem_wait[%0d]: got %h, want %h", i, got, want);
            end
        end
    endtask

    task automatic test_multi_stall();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        do_reset();
        st.push_back(mkStim(1, 0, 0, 0, 0, 0, 1, 32'h40)); ex.push_back(mkExp(K_EXC, 32'h0, 2'b00, 0));
        st.push_back(idle());                             ex.push_back(mkExp(K_VEC, 32'h40, 2'b10, 0));
        st.push_back(ldS1());                             ex.push_back(mkExp(K_BUB, 32'h40, 2'b10, 0));
        st.push_back(idle());                             ex.push_back(mkExp(K_BUB, 32'h40, 2'b10, 1));
        st.push_back(idle());                             ex.push_back(mkExp(K_BUB, 32'h40, 2'b10, 2));
        st.push_back(idle());                             ex.push_back(mkExp(K_RUN, 32'h40, 2'b10, 3));
        st.push_back(ldS1());                             ex.push_back(mkExp(K_BUB, 32'h40, 2'b10, 3));
        st.push_back(mkStim(1, 0, 0, 0, 1, 0, 0, 0));     ex.push_back(mkExp(K_FRZ, 32'h40, 2'b10, 4));
        st.push_back(idle());                             ex.push_back(mkExp(K_BUB, 32'h40, 2'b10, 5));
        st.push_back(idle());                             ex.push_back(mkExp(K_BUB, 32'h40, 2'b10, 6));
        st.push_back(idle());                             ex.push_back(mkExp(K_RUN, 32'h40, 2'b10, 7));
        st.push_back(ldS1());                             ex.push_back(mkExp(K_BUB, 32'h40, 2'b10, 7));
        st.push_back(mkStim(0, 0, 0, 0, 0, 0, 0, 0));     ex.push_back(mkExp(K_RST, 32'h40, 2'b10, 8));
        st.push_back(idle());                             ex.push_back(mkExp(K_RUN, 32'h0, 2'b00, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            got = sample(1); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL multi_stall[%0d]: got %h, want %h", i, got, want);
            end
        end
    endtask

    task automatic test_saturation();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                drive(mkStim(1, 0, 0, 0, 1, 0, 0, 0));
                sb.push_back(mkExp(K_FRZ, 0, 0, (i < 15) ? i : 15));
            end else begin
                drive(idle());
                sb.push_back(mkExp(K_RUN, 0, 0, 15));
            end
            @(negedge clk);
            got = sample(2); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL saturation[%0d]: got %h, want %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_exception();
        test_mem_wait();
        test_multi_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
